lvds_word_aligner: RTL and testbench
====================================

Name: lvds_word_aligner

Overview:
Parametrised successor to the fixed 8x8 LVDS bit-transpose. It takes the bit-interleaved parallel word from the SERDES bank and splits it into per-lane words using the same lane/bit mapping. It then word-aligns every lane independently with a barrel shifter, driven by a per-lane training-pattern search FSM. It sits between the SERDES bank and the IMX sync-code decoder and reports per-lane lock, shift and failure.

Parameters:
LANES, 8, number of LVDS lanes
SER, 8, deserialisation factor (bits per lane per clock), 4..16
TRAIN_WORD, 8'h9C, SER-bit training word; all SER rotations of it must be distinct (integrator's responsibility)
MATCH_COUNT, 4, consecutive matches needed to lock, >=1
MAX_SWEEPS, 4, full shift sweeps without a match before the lane declares failure, >=1

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
i_lvds  in  LANES*SER  interleaved SERDES word
i_valid  in  1  i_lvds qualifier; the pipeline and FSMs advance only when high
i_realign  in  1  single-cycle pulse; restarts alignment on all lanes
o_data  out  LANES*SER  aligned words; lane L occupies [L*SER +: SER]
o_valid  out  1  o_data qualifier
o_lane_locked  out  LANES  per-lane lock
o_all_locked  out  1  AND of o_lane_locked, registered
o_lane_fail  out  LANES  per-lane sticky failure
o_shift  out  LANES*$clog2(SER)  per-lane current shift

Behaviour:
- Transpose: lane L bit b = i_lvds[(SER-1-b)*LANES + (LANES-1-L)]. At LANES=SER=8 this is identical to the legacy mapping.
- Stage 1, on i_valid: the transposed word is registered as cur, and the previous cur moves to prev.
- Window: win_L = {prev_L,cur_L}[SER-1+s : s], where s is the lane's shift. It is combinational.
- Stage 2, on i_valid: o_data <= win.
- Latency: i_lvds to o_data is 2 valid cycles. o_valid is i_valid delayed 2 clocks.
- Data always flows, locked or not, using the current shift. While i_valid is low, all registers and FSMs hold.
- Per-lane FSM states: SEARCH, CONFIRM, LOCKED, FAIL. Evaluation uses win_L against TRAIN_WORD on valid cycles only.
- SEARCH, match: go to CONFIRM, cnt=1, shift unchanged.
- SEARCH, mismatch: shift = shift+1, wrapping SER-1 to 0. On each wrap, sweeps++.
- SEARCH, sweeps reaching MAX_SWEEPS: go to FAIL.
- CONFIRM, match: cnt++. When cnt reaches MATCH_COUNT, go to LOCKED. Lock is asserted one clock after the MATCH_COUNT-th consecutive match. If MATCH_COUNT=1, SEARCH goes directly to LOCKED.
- CONFIRM, mismatch: back to SEARCH, shift+1, cnt=0.
- LOCKED: shift frozen and data ignored. It is left only via i_realign or rst.
- FAIL: o_lane_fail=1, shift frozen. It is left only via i_realign or rst.
- i_realign, in any state: the next state is SEARCH with shift=0, cnt=0, sweeps=0, locked=0, fail=0. i_realign takes priority over a simultaneous match or lock. It acts regardless of i_valid.
- Reset (also mid-operation): all outputs 0, prev/cur 0, state SEARCH, shift 0, counters 0.
- Widths: cnt is $clog2(MATCH_COUNT+1) bits; sweeps is $clog2(MAX_SWEEPS+1) bits.
- o_all_locked is registered from o_lane_locked, so it lags o_lane_locked by one clock.

Decomposition:
- Shared package lvds_pkg holds: the FSM state enum (SEARCH, CONFIRM, LOCKED, FAIL), the width helper for SHIFT_W = $clog2(SER), and a transpose index function.
- The top level owns the transpose and the stage registers.
- Sub-module lvds_lane_align, generated LANES times, contains one lane's prev/cur registers, barrel window, FSM and counters.

Test Plan:
1. Transpose: hold i_valid=1 with the FSMs locked at shift 0, and drive i_lvds so lane0 = 8'hA5 and lane7 = 8'h3C every cycle -> o_data[7:0]=8'hA5 and [63:56]=8'h3C, 2 cycles after the input.
2. Per-lane offsets: lane3 constant 8'h39 (rotl 1), lane5 constant 8'h93 (rotl 5), the others 8'h9C -> o_shift lane3=1, lane5=5, others 0. All lanes lock after MATCH_COUNT matches; o_all_locked rises 1 clock after the last lane locks. Aligned o_data = 8'h9C on every lane.
3. Confirm break: lane0 = 8'h9C for 2 cycles, then 8'h00 once, then 8'h9C -> o_shift 0 -> 1 on the mismatch. No lock until a full MATCH_COUNT run is seen at the new alignment.
4. No pattern: all lanes constant 8'h00 -> o_lane_fail = 8'hFF after exactly MAX_SWEEPS*SER = 32 valid cycles, and o_lane_locked stays 0.
5. Realign and priority: pulse i_realign while locked -> next clock all lanes are in SEARCH with shift=0 and lock=0. Pulse i_realign on the same cycle as a lock-completing match -> the lane does not lock.
6. Stalls and reset: toggle i_valid 1-0-1-0 during a search -> shift and cnt advance only on valid cycles, and o_valid mirrors i_valid delayed 2. Assert rst mid-CONFIRM -> all outputs are 0 the next clock.

Source files
------------

// File: rtl/lvds_pkg.sv
// lvds_pkg: types and helpers shared by the LVDS word aligner and its lane slices.
package lvds_pkg;

   // Per-lane alignment FSM states.
   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_FAIL    = 2'd3
   } lane_state_e;

   // Width of a per-lane shift value for a deserialisation factor of ser.
   function automatic int shift_width(input int ser);
      return (ser > 1) ? $clog2(ser) : 1;
   endfunction

   // Position in the interleaved SERDES word of bit bit_idx of lane lane.
   function automatic int transpose_idx(input int lanes, input int ser,
                                        input int lane, input int bit_idx);
      return (ser - 1 - bit_idx) * lanes + (lanes - 1 - lane);
   endfunction

endpackage

// File: rtl/lvds_lane_align.sv
// lvds_lane_align: one lane's two-word history, barrel window, output register
// and training-pattern search FSM.
module lvds_lane_align
   import lvds_pkg::*;
#(
   parameter int             SER         = 8,
   parameter logic [SER-1:0] TRAIN_WORD  = SER'(8'h9C),
   parameter int             MATCH_COUNT = 4,
   parameter int             MAX_SWEEPS  = 4,
   parameter int             SHIFT_W     = shift_width(SER)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic               realign_i,
   input  logic [SER-1:0]     word_i,
   output logic [SER-1:0]     data_o,
   output logic               locked_o,
   output logic               fail_o,
   output logic [SHIFT_W-1:0] shift_o
);

   localparam int                 CNT_W      = $clog2(MATCH_COUNT + 1);
   localparam int                 SWP_W      = $clog2(MAX_SWEEPS + 1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LOCK   = CNT_W'(MATCH_COUNT);
   localparam logic [SWP_W-1:0]   SWP_FAIL   = SWP_W'(MAX_SWEEPS);
   localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SER - 1);

   logic [SER-1:0]     prev_q, cur_q, data_q;
   logic [2*SER-1:0]   pair;
   logic [SER-1:0]     win;
   logic               match;

   lane_state_e        state_q, state_d;
   logic [SHIFT_W-1:0] shift_q, shift_d, shift_inc;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [SWP_W-1:0]   sweeps_q, sweeps_d, sweeps_inc;
   logic               shift_wrap;
   logic               step;

   // The window straddles the previous and current word; a shift of s drops
   // the s oldest bits of cur and pulls s bits in from prev.
   assign pair  = {prev_q, cur_q};
   assign win   = pair[shift_q +: SER];
   assign match = (win == TRAIN_WORD);

   assign shift_wrap = (shift_q == SHIFT_LAST);
   assign shift_inc  = shift_wrap ? '0 : shift_q + SHIFT_W'(1);
   assign cnt_inc    = cnt_q + CNT_W'(1);
   assign sweeps_inc = sweeps_q + SWP_W'(1);

   // Word history and aligned output advance only on qualified beats.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with <= so every flop samples pre-edge values.
      if (rst) begin
         // NOTE: the data path is reset as well so o_data reads zero straight after reset.
         prev_q <= '0;
         cur_q  <= '0;
         data_q <= '0;
      end else if (valid_i) begin
         prev_q <= cur_q;
         cur_q  <= word_i;
         data_q <= win;
      end
   end

   // FSM state register with its shift and counter context.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_SEARCH;
         shift_q  <= '0;
         cnt_q    <= '0;
         sweeps_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         sweeps_q <= sweeps_d;
      end
   end

   // Next-state logic: realign wins over everything, otherwise evaluate on valid beats.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      sweeps_d = sweeps_q;
      step     = 1'b0;
      if (realign_i) begin
         state_d  = ST_SEARCH;
         shift_d  = '0;
         cnt_d    = '0;
         sweeps_d = '0;
      end else if (valid_i) begin
         case (state_q)
            ST_SEARCH: begin
               if (match) begin
                  cnt_d   = CNT_ONE;
                  state_d = (CNT_ONE == CNT_LOCK) ? ST_LOCKED : ST_CONFIRM;
               end else begin
                  step = 1'b1;
               end
            end
            ST_CONFIRM: begin
               if (match) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_LOCK) state_d = ST_LOCKED;
               end else begin
                  cnt_d = '0;
                  step  = 1'b1;
               end
            end
            default: ;  // LOCKED and FAIL hold until realign or reset
         endcase
         // A mismatch moves to the next candidate shift; a completed sweep is counted.
         if (step) begin
            state_d = ST_SEARCH;
            shift_d = shift_inc;
            if (shift_wrap) begin
               sweeps_d = sweeps_inc;
               if (sweeps_inc == SWP_FAIL) state_d = ST_FAIL;
            end
         end
      end
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      locked_o = (state_q == ST_LOCKED);
      fail_o   = (state_q == ST_FAIL);
   end

   assign data_o  = data_q;
   assign shift_o = shift_q;

endmodule

// File: rtl/lvds_word_aligner.sv
// lvds_word_aligner: splits the interleaved SERDES word into per-lane words and
// word-aligns every lane independently against a training word.
module lvds_word_aligner
   import lvds_pkg::*;
#(
   parameter int             LANES       = 8,
   parameter int             SER         = 8,
   parameter logic [SER-1:0] TRAIN_WORD  = SER'(8'h9C),
   parameter int             MATCH_COUNT = 4,
   parameter int             MAX_SWEEPS  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LANES*SER-1:0]         i_lvds,
   input  logic                         i_valid,
   input  logic                         i_realign,
   output logic [LANES*SER-1:0]         o_data,
   output logic                         o_valid,
   output logic [LANES-1:0]             o_lane_locked,
   output logic                         o_all_locked,
   output logic [LANES-1:0]             o_lane_fail,
   output logic [LANES*$clog2(SER)-1:0] o_shift
);

   localparam int SHIFT_W = shift_width(SER);

   logic [LANES-1:0] lane_locked;
   logic             valid_d1_q, valid_q, all_locked_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [SER-1:0] word;

      // Transpose is pure wiring: lane l bit b comes from the interleaved position.
      for (genvar b = 0; b < SER; b++) begin : g_bit
         assign word[b] = i_lvds[transpose_idx(LANES, SER, l, b)];
      end

      lvds_lane_align #(
         .SER         (SER),
         .TRAIN_WORD  (TRAIN_WORD),
         .MATCH_COUNT (MATCH_COUNT),
         .MAX_SWEEPS  (MAX_SWEEPS),
         .SHIFT_W     (SHIFT_W)
      ) u_align (
         .clk       (clk),
         .rst       (rst),
         .valid_i   (i_valid),
         .realign_i (i_realign),
         .word_i    (word),
         .data_o    (o_data[l*SER +: SER]),
         .locked_o  (lane_locked[l]),
         .fail_o    (o_lane_fail[l]),
         .shift_o   (o_shift[l*SHIFT_W +: SHIFT_W])
      );
   end

   // o_valid trails i_valid by two clocks; the aggregate lock trails the lanes by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_d1_q   <= 1'b0;
         valid_q      <= 1'b0;
         all_locked_q <= 1'b0;
      end else begin
         valid_d1_q   <= i_valid;
         valid_q      <= valid_d1_q;
         all_locked_q <= &lane_locked;
      end
   end

   assign o_valid       = valid_q;
   assign o_lane_locked = lane_locked;
   assign o_all_locked  = all_locked_q;

endmodule

// File: tb/tb_lvds_word_aligner.sv
// tb_lvds_word_aligner: directed stimulus with a queue-based data scoreboard
// plus direct status checks for lock, shift, failure and reset behaviour.
module tb_lvds_word_aligner;

   localparam int LANES   = 8;
   localparam int SER     = 8;
   localparam int SHIFT_W = 3;

   typedef logic [LANES-1:0][SER-1:0] lanes_t;
   typedef struct packed {
      logic        chk;
      logic [63:0] data;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   i_valid = 1'b0;
   logic                   i_realign = 1'b0;
   logic [LANES*SER-1:0]   i_lvds = '0;
   logic [LANES*SER-1:0]   o_data;
   logic                   o_valid;
   logic [LANES-1:0]       o_lane_locked;
   logic                   o_all_locked;
   logic [LANES-1:0]       o_lane_fail;
   logic [LANES*SHIFT_W-1:0] o_shift;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   lvds_word_aligner #(
      .LANES       (LANES),
      .SER         (SER),
      .TRAIN_WORD  (8'h9C),
      .MATCH_COUNT (4),
      .MAX_SWEEPS  (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_lvds        (i_lvds),
      .i_valid       (i_valid),
      .i_realign     (i_realign),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .o_lane_locked (o_lane_locked),
      .o_all_locked  (o_all_locked),
      .o_lane_fail   (o_lane_fail),
      .o_shift       (o_shift)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Interleave per-lane words into the SERDES bit order.
   function automatic logic [63:0] pack(input lanes_t w);
      logic [63:0] v;
      v = '0;
      for (int l = 0; l < LANES; l++)
         for (int b = 0; b < SER; b++)
            v[(SER-1-b)*LANES + (LANES-1-l)] = w[l][b];
      return v;
   endfunction

   // One qualified beat; the expectation for the output it produces is queued.
   task automatic beat(input logic [63:0] lvds, input logic chk, input logic [63:0] exp);
      i_lvds  = lvds;
      i_valid = 1'b1;
      sb_q.push_back({chk, exp});
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic realign_pulse();
      i_valid   = 1'b0;
      i_realign = 1'b1;
      @(posedge clk); #1;
      i_realign = 1'b0;
   endtask

   // Fill prev/cur with the word, then restart alignment so the search sees it at once.
   task automatic prime(input logic [63:0] lvds);
      beat(lvds, 1'b0, '0);
      beat(lvds, 1'b0, '0);
      realign_pulse();
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      rst     = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
   endtask

   // Monitor: every presented output pops one expectation.
   always @(negedge clk) begin
      if (o_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got o_valid=1, expected no output");
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) check("sb_data", o_data, mon_e.data);
         end
      end
   end

   initial begin
      lanes_t w, w0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      check("rst_data",   o_data, 64'd0);
      check("rst_valid",  64'(o_valid), 64'd0);
      check("rst_locked", 64'(o_lane_locked), 64'd0);
      check("rst_all",    64'(o_all_locked), 64'd0);
      check("rst_fail",   64'(o_lane_fail), 64'd0);
      check("rst_shift",  64'(o_shift), 64'd0);

      // Lock every lane at shift 0
      w = {LANES{8'h9C}};
      prime(pack(w));
      repeat (3) beat(pack(w), 1'b0, '0);
      check("a_locked_3", 64'(o_lane_locked), 64'h00);
      beat(pack(w), 1'b0, '0);
      check("a_locked_4", 64'(o_lane_locked), 64'hFF);
      check("a_all_lag",  64'(o_all_locked), 64'd0);
      idle(1);
      check("a_all",      64'(o_all_locked), 64'd1);

      // Transpose: lane0=A5, lane7=3C, hand-interleaved
      repeat (3) beat(64'h8000810101810080, 1'b1, 64'h3C000000000000A5);
      beat(64'h8000810101810080, 1'b0, '0);
      check("t1_locked", 64'(o_lane_locked), 64'hFF);
      check("t1_shift",  64'(o_shift), 64'd0);

      // Realign while locked
      realign_pulse();
      check("t5_locked", 64'(o_lane_locked), 64'h00);
      check("t5_shift",  64'(o_shift), 64'd0);
      check("t5_all_lag", 64'(o_all_locked), 64'd1);
      idle(1);
      check("t5_all",    64'(o_all_locked), 64'd0);

      // Per-lane offsets: lane3 rotl 1, lane5 rotl 5
      w = {LANES{8'h9C}};
      w[3] = 8'h39;
      w[5] = 8'h93;
      prime(pack(w));
      for (int i = 1; i <= 9; i++) begin
         beat(pack(w), 1'b0, '0);
         if (i == 4) check("t2_locked_4", 64'(o_lane_locked), 64'hD7);
         if (i == 5) check("t2_locked_5", 64'(o_lane_locked), 64'hDF);
         if (i == 8) check("t2_locked_8", 64'(o_lane_locked), 64'hDF);
      end
      check("t2_locked_9", 64'(o_lane_locked), 64'hFF);
      check("t2_all_lag",  64'(o_all_locked), 64'd0);
      check("t2_shift",    64'(o_shift), 64'h028200);
      idle(1);
      check("t2_all",      64'(o_all_locked), 64'd1);
      repeat (4) beat(pack(w), 1'b1, {LANES{8'h9C}});
      beat(pack(w), 1'b0, '0);

      // Confirm break on lane0
      w  = {LANES{8'h9C}};
      w0 = w;
      w0[0] = 8'h00;
      prime(pack(w));
      for (int i = 1; i <= 15; i++) begin
         beat((i == 3) ? pack(w0) : pack(w), 1'b0, '0);
         if (i == 3)  check("t3_locked_3",  64'(o_lane_locked), 64'h00);
         if (i == 4)  check("t3_locked_4",  64'(o_lane_locked), 64'hFE);
         if (i == 4)  check("t3_shift_4",   64'(o_shift), 64'h000001);
         if (i == 11) check("t3_shift_11",  64'(o_shift), 64'h000000);
         if (i == 14) check("t3_locked_14", 64'(o_lane_locked), 64'hFE);
      end
      check("t3_locked_15", 64'(o_lane_locked), 64'hFF);
      check("t3_shift_15",  64'(o_shift), 64'h000000);

      // No pattern: fail after exactly 32 valid beats
      w = '0;
      prime(pack(w));
      for (int i = 1; i <= 32; i++) begin
         beat(pack(w), 1'b0, '0);
         if (i == 31) check("t4_fail_31",  64'(o_lane_fail), 64'h00);
         if (i == 31) check("t4_shift_31", 64'(o_shift), 64'hFFFFFF);
      end
      check("t4_fail_32",   64'(o_lane_fail), 64'hFF);
      check("t4_locked_32", 64'(o_lane_locked), 64'h00);
      repeat (3) beat(pack(w), 1'b0, '0);
      check("t4_fail_hold",  64'(o_lane_fail), 64'hFF);
      check("t4_shift_hold", 64'(o_shift), 64'h000000);

      // Realign clears failure; realign beats a lock-completing match
      w = {LANES{8'h9C}};
      prime(pack(w));
      check("t5_fail_clr", 64'(o_lane_fail), 64'h00);
      repeat (3) beat(pack(w), 1'b0, '0);
      i_realign = 1'b1;
      beat(pack(w), 1'b0, '0);
      i_realign = 1'b0;
      check("t5_prio_locked", 64'(o_lane_locked), 64'h00);
      check("t5_prio_shift",  64'(o_shift), 64'd0);
      for (int i = 5; i <= 8; i++) begin
         beat(pack(w), 1'b0, '0);
         if (i == 7) check("t5_relock_7", 64'(o_lane_locked), 64'h00);
      end
      check("t5_relock_8", 64'(o_lane_locked), 64'hFF);

      // Stalls: shift advances on valid beats only, o_valid is i_valid delayed 2
      w = '0;
      prime(pack(w));
      beat(pack(w), 1'b0, '0);
      check("t6_shift_v1", 64'(o_shift), 64'h249249);
      check("t6_ovalid_1", 64'(o_valid), 64'd0);
      idle(1);
      check("t6_shift_s1", 64'(o_shift), 64'h249249);
      check("t6_ovalid_2", 64'(o_valid), 64'd1);
      beat(pack(w), 1'b0, '0);
      check("t6_shift_v2", 64'(o_shift), 64'h492492);
      check("t6_ovalid_3", 64'(o_valid), 64'd0);
      idle(1);
      check("t6_shift_s2", 64'(o_shift), 64'h492492);
      check("t6_ovalid_4", 64'(o_valid), 64'd1);
      idle(1);
      check("t6_ovalid_5", 64'(o_valid), 64'd0);

      // Reset mid-CONFIRM
      w = {LANES{8'h9C}};
      prime(pack(w));
      repeat (2) beat(pack(w), 1'b0, '0);
      do_reset();
      check("t6_rst_data",   o_data, 64'd0);
      check("t6_rst_valid",  64'(o_valid), 64'd0);
      check("t6_rst_locked", 64'(o_lane_locked), 64'd0);
      check("t6_rst_all",    64'(o_all_locked), 64'd0);
      check("t6_rst_fail",   64'(o_lane_fail), 64'd0);
      check("t6_rst_shift",  64'(o_shift), 64'd0);

      // Recovery after reset
      prime(pack(w));
      repeat (4) beat(pack(w), 1'b0, '0);
      check("rec_locked", 64'(o_lane_locked), 64'hFF);

      idle(4);
      check("sb_drain", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
